bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares one single-port 32-bit BRAM (registered addr + registered data, 2-cycle read latency, no byte enables) between NUM_PORTS requesters.
//  Round-robin arbitration, req/gnt/rvalid protocol (one-cycle grant, in-order responses), per-port response routing; optional byte-enable RMW.
//  Sits between core/DMA-side memory ports and the FPGA BRAM instance in the FPGA memory subsystem.
// PARAMETERS
//  NUM_PORTS    2    number of requesters (>=1)
//  MEM_SIZE_KB  512  BRAM capacity; localparam ADDR_WIDTH = $clog2(MEM_SIZE_KB*1024/4) (word address)
// PORTS
//  clock        in   1                        single clock; all logic on posedge
//  reset        in   1                        synchronous, active-high
//  req_i        in   [NUM_PORTS]              request valid per port
//  gnt_o        out  [NUM_PORTS]              grant, combinational from req_i, one-hot or zero
//  addr_i       in   [NUM_PORTS][ADDR_WIDTH]  word address
//  we_i         in   [NUM_PORTS]              1 = write
//  be_i         in   [NUM_PORTS][4]           byte enables (used only with BRAM_ARB_RMW_EN)
//  wdata_i      in   [NUM_PORTS][32]          write data
//  rvalid_o     out  [NUM_PORTS]              response valid (reads and writes)
//  rdata_o      out  [NUM_PORTS][32]          read data, valid with rvalid_o on reads
//  mem_we_o     out  1                        to BRAM we
//  mem_addr_o   out  ADDR_WIDTH               to BRAM addr
//  mem_wdata_o  out  32                       to BRAM data_in
//  mem_rdata_i  in   32                       from BRAM data_out
// BEHAVIOUR
//  Reset: gnt_o=0, rvalid_o=0, mem_we_o=0, mem_addr_o=0, rr pointer=0, FSM=IDLE, response pipe cleared.
//  Reset mid-operation: in-flight responses dropped, no rvalid; a pending RMW write is abandoned (mem_we_o=0).
//  Arbitration: in IDLE, at most one gnt per cycle; search starts at rr pointer.
//   On grant to port k, pointer <= (k+1) mod NUM_PORTS; pointer holds when nothing is granted.
//  Requester holds req/addr/we/be/wdata stable until gnt; gnt cycle = acceptance cycle T.
//  Issue: in cycle T mem_addr_o = addr_i[k], mem_we_o = we_i[k], mem_wdata_o = wdata_i[k].
//  Idle cycles drive mem_we_o=0; mem_addr_o holds its last value.
//  Response: 2-deep pipe of {valid, port idx}; rvalid_o[k]=1 in cycle T+2 exactly.
//   rdata_o[k] = mem_rdata_i, routed combinationally; rdata_o of non-responding ports = 0.
//  Throughput: one access per cycle, back-to-back, any port mix; responses in grant order.
//  Read-after-write to same address in T, T+1 returns the new data (BRAM write lands end of T).
//  FSM states: IDLE, RMW_RD, RMW_WAIT, RMW_WR (RMW states exist only with the macro).
// CONFIGURATION
//  BRAM_ARB_RMW_EN defined:
//   Write with be==4'hF: single cycle, as above.
//   Write with be==4'h0: issued as a read (mem_we_o=0), rvalid at T+2.
//   Partial be: IDLE -> RMW_RD (T: read issued, gnt given) -> RMW_WAIT (T+1) -> RMW_WR (T+2).
//    In RMW_WR, merge mem_rdata_i with latched wdata per byte, mem_we_o=1; rvalid_o[k] at T+2; then IDLE.
//    No grants in T+1..T+2; earlier in-flight responses still drain on time.
//  Not defined: be_i ignored, every write is full-word single-cycle, FSM is IDLE-only, gnt never stalls.
// STRUCTURE
//  Package bram_arb_pkg: state enum (IDLE/RMW_RD/RMW_WAIT/RMW_WR), MEM_LATENCY=2, BE_FULL=4'hF.
//  Sub-module bram_rr_arbiter: req vector + pointer -> one-hot gnt + granted index.
//   Its enable input is low outside IDLE.
//  Top holds issue mux, response pipe, RMW FSM and merge logic.
// TESTING
//  1 Single port: write 0xDEADBEEF @0x10 at T, read @0x10 at T+1 -> write rvalid T+2, read rvalid T+3 with 0xDEADBEEF.
//  2 Both ports req every cycle for 8 cycles -> grants alternate 0,1,0,1...; each rvalid 2 cycles after its gnt on the right port.
//  3 Port 1 only requesting after port 0 grant -> port 1 granted same cycle; pointer then returns to 0.
//  4 RMW_EN: mem@0x20=0x11223344, write be=4'b0010 wdata=0x0000AA00 -> gnt, no grants for 2 cycles, rvalid T+2; read gives 0x1122AA44.
//  5 No RMW_EN: same stimulus as 4 -> single-cycle write; read gives 0x0000AA00.
//  6 Reset asserted at T+1 of a read -> no rvalid follows, gnt/rvalid/mem_we 0 during reset; first post-reset grant to port 0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types, constants and helpers for the BRAM port arbiter.
package bram_arb_pkg;

  // StRmwRd names the read-issue cycle, which the FSM spends in StIdle while granting.
  typedef enum logic [1:0] {
    StIdle,
    StRmwRd,
    StRmwWait,
    StRmwWr
  } arb_state_e;

  localparam int unsigned MEM_LATENCY = 2;
  localparam logic [3:0]  BE_FULL     = 4'hF;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_data,
                                           input logic [31:0] new_data,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_data;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_data[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W = idx_width(NUM_PORTS)
) (
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_PORTS)) sum = sum - (IDX_W+1)'(NUM_PORTS);
      cand = sum[IDX_W-1:0];
      if (en_i && !valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 2-cycle-latency single-port BRAM between NUM_PORTS req/gnt/rvalid requesters.
// Define BRAM_ARB_RMW_EN to honour partial byte enables via read-modify-write.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned MEM_SIZE_KB = 512,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_SIZE_KB * 1024 / 4),
  localparam int unsigned IDX_W      = idx_width(NUM_PORTS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 req_i,
  output logic [NUM_PORTS-1:0]                 gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0]                 we_i,
  input  logic [NUM_PORTS-1:0][3:0]            be_i,
  input  logic [NUM_PORTS-1:0][31:0]           wdata_i,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [NUM_PORTS-1:0][31:0]           rdata_o,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [31:0]                          mem_wdata_o,
  input  logic [31:0]                          mem_rdata_i
);

  arb_state_e                            state_q, state_d;
  logic [IDX_W-1:0]                      ptr_q, ptr_d;
  logic [MEM_LATENCY-1:0]                pipe_vld_q, pipe_vld_d;
  logic [MEM_LATENCY-1:0][IDX_W-1:0]     pipe_idx_q, pipe_idx_d;
  logic [ADDR_WIDTH-1:0]                 last_addr_q, last_addr_d;

  logic                                  arb_en;
  logic                                  gnt_valid;
  logic [IDX_W-1:0]                      gnt_idx;

  bram_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_arbiter (
    .en_i   (arb_en),
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt_o),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  assign arb_en = (state_q == StIdle) && !reset;

`ifdef BRAM_ARB_RMW_EN
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [31:0]           rmw_wdata_q, rmw_wdata_d;
  logic [3:0]            rmw_be_q, rmw_be_d;
`else
  logic unused_be;
  assign unused_be = ^be_i;
`endif

  // Issue mux, RMW sequencing and pointer/pipe next state.
  always_comb begin
    state_d     = state_q;
    mem_we_o    = 1'b0;
    mem_addr_o  = last_addr_q;
    mem_wdata_o = '0;
`ifdef BRAM_ARB_RMW_EN
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_be_d    = rmw_be_q;
`endif

    if (gnt_valid) begin
      mem_addr_o  = addr_i[gnt_idx];
      mem_we_o    = we_i[gnt_idx];
      mem_wdata_o = wdata_i[gnt_idx];
`ifdef BRAM_ARB_RMW_EN
      // Partial writes read first; be==0 degenerates to a plain read.
      if (we_i[gnt_idx] && (be_i[gnt_idx] != BE_FULL)) begin
        mem_we_o = 1'b0;
        if (be_i[gnt_idx] != 4'h0) begin
          state_d     = StRmwWait;
          rmw_addr_d  = addr_i[gnt_idx];
          rmw_wdata_d = wdata_i[gnt_idx];
          rmw_be_d    = be_i[gnt_idx];
        end
      end
`endif
    end

`ifdef BRAM_ARB_RMW_EN
    unique case (state_q)
      StRmwWait: state_d = StRmwWr;
      StRmwWr: begin
        state_d     = StIdle;
        mem_we_o    = 1'b1;
        mem_addr_o  = rmw_addr_q;
        mem_wdata_o = be_merge(mem_rdata_i, rmw_wdata_q, rmw_be_q);
      end
      default: ;
    endcase
`endif

    if (reset) begin
      mem_we_o   = 1'b0;
      mem_addr_o = '0;
    end

    last_addr_d = mem_addr_o;

    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    pipe_vld_d = {pipe_vld_q[MEM_LATENCY-2:0], gnt_valid};
    pipe_idx_d = {pipe_idx_q[MEM_LATENCY-2:0], gnt_idx};
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = !reset && pipe_vld_q[MEM_LATENCY-1] &&
                    (pipe_idx_q[MEM_LATENCY-1] == IDX_W'(p));
      rdata_o[p]  = rvalid_o[p] ? mem_rdata_i : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      pipe_vld_q  <= '0;
      pipe_idx_q  <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_idx_q  <= pipe_idx_d;
      last_addr_q <= last_addr_d;
    end
  end

`ifdef BRAM_ARB_RMW_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_be_q    <= '0;
    end else begin
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_be_q    <= rmw_be_d;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: BRAM model, transaction-level reference model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_bram_port_arbiter;

  localparam int NP = 2;
  localparam int KB = 4;
  localparam int AW = $clog2(KB * 1024 / 4);
  localparam int WORDS = 1 << AW;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NP-1:0]         req_i;
  logic [NP-1:0]         gnt_o;
  logic [NP-1:0][AW-1:0] addr_i;
  logic [NP-1:0]         we_i;
  logic [NP-1:0][3:0]    be_i;
  logic [NP-1:0][31:0]   wdata_i;
  logic [NP-1:0]         rvalid_o;
  logic [NP-1:0][31:0]   rdata_o;
  logic                  mem_we_o;
  logic [AW-1:0]         mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  bit          p_req[NP];
  logic [AW-1:0] p_addr[NP];
  bit          p_we[NP];
  logic [3:0]  p_be[NP];
  logic [31:0] p_wdata[NP];

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign req_i[g]   = p_req[g];
    assign addr_i[g]  = p_addr[g];
    assign we_i[g]    = p_we[g];
    assign be_i[g]    = p_be[g];
    assign wdata_i[g] = p_wdata[g];
  end

  bram_port_arbiter #(
    .NUM_PORTS  (NP),
    .MEM_SIZE_KB(KB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // BRAM: registered address, registered output, write lands at the clock edge.
  logic [31:0]   bram [WORDS];
  logic [AW-1:0] bram_addr_q = '0;
  logic [31:0]   bram_dout_q = '0;
  always @(posedge clock) begin
    if (mem_we_o) bram[mem_addr_o] <= mem_wdata_o;
    bram_addr_q <= mem_addr_o;
    bram_dout_q <= bram[bram_addr_q];
  end
  assign mem_rdata_i = bram_dout_q;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

`ifdef BRAM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  // Reference model: memory contents as seen in grant order, expected responses, rr pointer.
  typedef struct {
    int          cyc;
    int          port;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  logic [31:0] ref_mem [WORDS];
  resp_t       pend[$];
  resp_t       rlog[$];
  int          ptr = 0;
  int          busy_until = -1;
  int          wr_cyc = -1;
  logic [31:0] wr_data = '0;
  logic [AW-1:0] last_addr = '0;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end
  end

  always @(negedge clock) begin : cmp
    logic [NP-1:0] eg, ev;
    logic [AW-1:0] ea;
    logic [31:0]   ewd;
    bit            ewe;
    int            k, j;
    resp_t         r;
    for (int p = 0; p < NP; p++) begin
      if (rvalid_o[p]) begin
        r.cyc = cyc; r.port = p; r.rd = 1'b0; r.data = rdata_o[p];
        rlog.push_back(r);
      end
    end
    if (reset) begin
      chk("reset_gnt", 32'(gnt_o), 32'd0);
      chk("reset_rvalid", 32'(rvalid_o), 32'd0);
      chk("reset_mem_we", 32'(mem_we_o), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr_o), 32'd0);
      ptr = 0; pend.delete(); busy_until = -1; wr_cyc = -1; last_addr = '0;
    end else begin
      eg = '0; k = -1;
      if (cyc > busy_until) begin
        for (int i = 0; i < NP; i++) begin
          j = (ptr + i) % NP;
          if (k < 0 && p_req[j]) k = j;
        end
      end
      if (k >= 0) eg[k] = 1'b1;
      chk("gnt", 32'(gnt_o), 32'(eg));

      ev = '0;
      if (pend.size() > 0 && pend[0].cyc == cyc) ev[pend[0].port] = 1'b1;
      chk("rvalid", 32'(rvalid_o), 32'(ev));
      for (int p = 0; p < NP; p++) begin
        if (ev[p] && pend[0].rd) chk("rdata", rdata_o[p], pend[0].data);
        else if (!ev[p]) chk("rdata_idle", rdata_o[p], 32'd0);
      end
      if (ev != '0) void'(pend.pop_front());

      ea = last_addr; ewe = 1'b0; ewd = '0;
      if (k >= 0) begin
        ea = p_addr[k];
        r.cyc = cyc + 2; r.port = k; r.rd = !p_we[k]; r.data = ref_mem[ea];
        pend.push_back(r);
        if (p_we[k]) begin
          if (!RMW || p_be[k] == 4'hF) begin
            ewe = 1'b1; ewd = p_wdata[k]; ref_mem[ea] = p_wdata[k];
          end else if (p_be[k] != 4'h0) begin
            wr_data = merge_bytes(ref_mem[ea], p_wdata[k], p_be[k]);
            ref_mem[ea] = wr_data;
            wr_cyc = cyc + 2; busy_until = cyc + 2;
          end
        end
        ptr = (k + 1) % NP;
        last_addr = ea;
      end
      if (cyc == wr_cyc) begin
        ewe = 1'b1; ewd = wr_data;
      end
      chk("mem_we", 32'(mem_we_o), 32'(ewe));
      chk("mem_addr", 32'(mem_addr_o), 32'(ea));
      if (ewe) chk("mem_wdata", mem_wdata_o, ewd);
    end
  end

  task automatic issue(input int p, input logic [AW-1:0] a, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, output int gcyc);
    int n;
    n = 0; gcyc = -1;
    p_addr[p] = a; p_we[p] = we; p_be[p] = be; p_wdata[p] = wd; p_req[p] = 1'b1;
    while (gcyc < 0 && n < 50) begin
      @(negedge clock);
      n++;
      if (gnt_o[p]) gcyc = cyc;
    end
    if (gcyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL grant_timeout: port %0d got no grant, expected one within 50 cycles", p);
    end
    @(posedge clock);
    #1;
    p_req[p] = 1'b0;
  endtask

  function automatic bit find_resp(input int port, input int c, output logic [31:0] d);
    d = '0;
    foreach (rlog[i]) begin
      if (rlog[i].port == port && rlog[i].cyc == c) begin
        d = rlog[i].data;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int          ga, gb, gw, gr, gk;
  int          g0s[4], g1s[4];
  logic [31:0] d;
  bit          f;

  initial begin
    for (int p = 0; p < NP; p++) begin
      p_req[p] = 1'b0; p_addr[p] = '0; p_we[p] = 1'b0; p_be[p] = 4'hF; p_wdata[p] = '0;
    end
    idle(3);
    reset = 1'b0;
    idle(1);

    // Write then immediate read of the same word.
    issue(0, AW'('h10), 1'b1, 4'hF, 32'hDEADBEEF, ga);
    issue(0, AW'('h10), 1'b0, 4'hF, 32'h0, gb);
    chk("t1_read_next_cycle", 32'(gb), 32'(ga + 1));
    idle(4);
    f = find_resp(0, ga + 2, d);
    chk("t1_write_rvalid_t2", 32'(f), 32'd1);
    f = find_resp(0, gb + 2, d);
    chk("t1_read_rvalid_t3", 32'(f), 32'd1);
    chk("t1_read_data", d, 32'hDEADBEEF);

    // Lone port 1 after a port 0 grant is served at once; pointer wraps back to 0.
    issue(0, AW'('h11), 1'b0, 4'hF, 32'h0, ga);
    issue(1, AW'('h12), 1'b0, 4'hF, 32'h0, gb);
    chk("t3_port1_same_cycle", 32'(gb), 32'(ga + 1));
    idle(2);

    // Both ports every cycle: port 0 writes, port 1 reads the same word one cycle later.
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, AW'('h40 + i), 1'b1, 4'hF, 32'hA5A50000 + i, g0s[i]);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, AW'('h40 + i), 1'b0, 4'hF, 32'h0, g1s[i]);
      end
    join
    idle(4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_port0_slot", 32'(g0s[i]), 32'(g0s[0] + 2 * i));
      chk("t2_port1_slot", 32'(g1s[i]), 32'(g0s[0] + 2 * i + 1));
      f = find_resp(1, g1s[i] + 2, d);
      chk("t2_raw_data", d, 32'hA5A50000 + i);
    end

    // Partial byte-enable write.
    issue(0, AW'('h20), 1'b1, 4'hF, 32'h11223344, ga);
    issue(0, AW'('h20), 1'b1, 4'b0010, 32'h0000AA00, gw);
    issue(0, AW'('h20), 1'b0, 4'hF, 32'h0, gr);
    chk("t4_next_grant_gap", 32'(gr - gw), RMW ? 32'd3 : 32'd1);
    idle(4);
    f = find_resp(0, gw + 2, d);
    chk("t4_write_rvalid_t2", 32'(f), 32'd1);
    f = find_resp(0, gr + 2, d);
    chk("t4_read_data", d, RMW ? 32'h1122AA44 : 32'h0000AA00);

    // Reset one cycle after a read grant: response dropped, pointer back to 0.
    issue(0, AW'('h10), 1'b0, 4'hF, 32'h0, gk);
    reset = 1'b1;
    p_addr[1] = AW'('h31); p_we[1] = 1'b0; p_req[1] = 1'b1;
    idle(1);
    reset = 1'b0;
    p_req[1] = 1'b0;
    fork
      issue(0, AW'('h30), 1'b0, 4'hF, 32'h0, ga);
      issue(1, AW'('h31), 1'b0, 4'hF, 32'h0, gb);
    join
    idle(4);
    f = find_resp(0, gk + 2, d);
    chk("t6_dropped_rvalid", 32'(f), 32'd0);
    chk("t6_port0_first", 32'(gb - ga), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
